// File: rtl/hit_reaction_ctrl_if.sv
// Collision-result and status bundle between the collision/HUD side and
// one player's hit-reaction controller.
interface hit_reaction_ctrl_if;
  logic       frame_tick;
  logic       round_reset;
  logic       got_hit;
  logic       got_blocked;
  logic       in_hitstun;
  logic       in_blockstun;
  logic       hurtbox_en;
  logic       ko;
  logic [7:0] health;
  logic [3:0] guard;
  logic       hit_pulse;
  logic       block_pulse;
  logic       gbreak_pulse;

  // Collision/game side: drives levels and ticks, observes status
  modport master (
    output frame_tick, round_reset, got_hit, got_blocked,
    input  in_hitstun, in_blockstun, hurtbox_en, ko, health, guard,
           hit_pulse, block_pulse, gbreak_pulse
  );

  // Controller side
  modport slave (
    input  frame_tick, round_reset, got_hit, got_blocked,
    output in_hitstun, in_blockstun, hurtbox_en, ko, health, guard,
           hit_pulse, block_pulse, gbreak_pulse
  );
endinterface

// File: rtl/hit_reaction_ctrl.sv
// Per-player hit reaction: turns got_hit/got_blocked levels into one-shot
// events, runs hitstun/blockstun timers, health, guard meter, regen and KO.
module hit_reaction_ctrl #(
  parameter int unsigned HEALTH_MAX       = 100,
  parameter int unsigned DAMAGE           = 10,
  parameter int unsigned GUARD_MAX        = 4,
  parameter int unsigned HITSTUN_FRAMES   = 20,
  parameter int unsigned BLOCKSTUN_FRAMES = 12,
  parameter int unsigned GBREAK_FRAMES    = 30,
  parameter int unsigned GUARD_REGEN      = 60
) (
  input logic                clk,
  input logic                rst,
  hit_reaction_ctrl_if.slave bus
);

  localparam logic [7:0] HP_MAX = 8'(HEALTH_MAX);
  localparam logic [7:0] DMG    = 8'(DAMAGE);
  localparam logic [3:0] GD_MAX = 4'(GUARD_MAX);
  localparam logic [7:0] HS_LD  = 8'(HITSTUN_FRAMES);
  localparam logic [7:0] BS_LD  = 8'(BLOCKSTUN_FRAMES);
  localparam logic [7:0] GB_LD  = 8'(GBREAK_FRAMES);
  localparam logic [7:0] RG_TOP = 8'(GUARD_REGEN - 1);

  typedef enum logic [1:0] {IDLE, HITSTUN, BLOCKSTUN, KO} state_t;

  state_t     state, state_nxt;
  logic [7:0] health, health_nxt;
  logic [3:0] guard, guard_nxt;
  logic [7:0] stun_cnt, stun_nxt;
  logic [7:0] regen_cnt, regen_nxt;
  logic       evt_prev;
  logic       evt_lvl, evt, accept;
  logic       hit_p_nxt, block_p_nxt, gbreak_p_nxt;
  logic       in_hitstun, in_blockstun, hurtbox_en, ko;
  logic       hit_pulse, block_pulse, gbreak_pulse;

  assign evt_lvl = bus.got_hit | bus.got_blocked;
  assign evt     = evt_lvl & ~evt_prev;
  // Edges arriving in HITSTUN/KO are dropped but still consumed via evt_prev
  assign accept  = evt & ((state == IDLE) | (state == BLOCKSTUN));

  // Next-state, counters and pulse decisions for the registered FSM
  always_comb begin
    state_nxt    = state;
    health_nxt   = health;
    guard_nxt    = guard;
    stun_nxt     = stun_cnt;
    regen_nxt    = regen_cnt;
    hit_p_nxt    = 1'b0;
    block_p_nxt  = 1'b0;
    gbreak_p_nxt = 1'b0;

    if (accept) begin
      regen_nxt = '0;
      if (bus.got_hit) begin
        hit_p_nxt  = 1'b1;
        health_nxt = (health > DMG) ? health - DMG : '0;
        if (health <= DMG) begin
          state_nxt = KO;
          stun_nxt  = '0;
        end else begin
          state_nxt = HITSTUN;
          stun_nxt  = HS_LD;
        end
      end else if (guard >= 4'd2) begin
        block_p_nxt = 1'b1;
        guard_nxt   = guard - 4'd1;
        state_nxt   = BLOCKSTUN;
        stun_nxt    = BS_LD;
      end else begin
        hit_p_nxt    = 1'b1;
        gbreak_p_nxt = 1'b1;
        guard_nxt    = '0;
        state_nxt    = HITSTUN;
        stun_nxt     = GB_LD;
      end
    end else if (bus.frame_tick) begin
      case (state)
        IDLE: begin
          if (regen_cnt >= RG_TOP) begin
            regen_nxt = '0;
            if (guard < GD_MAX) guard_nxt = guard + 4'd1;
          end else begin
            regen_nxt = regen_cnt + 8'd1;
          end
        end
        HITSTUN, BLOCKSTUN: begin
          if (stun_cnt <= 8'd1) begin
            state_nxt = IDLE;
            stun_nxt  = '0;
          end else begin
            stun_nxt = stun_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and all outputs registered; rst/round_reset restart the round
  always_ff @(posedge clk) begin
    if (rst || bus.round_reset) begin
      state        <= IDLE;
      health       <= HP_MAX;
      guard        <= GD_MAX;
      stun_cnt     <= '0;
      regen_cnt    <= '0;
      evt_prev     <= 1'b0;
      in_hitstun   <= 1'b0;
      in_blockstun <= 1'b0;
      hurtbox_en   <= 1'b1;
      ko           <= 1'b0;
      hit_pulse    <= 1'b0;
      block_pulse  <= 1'b0;
      gbreak_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      health       <= health_nxt;
      guard        <= guard_nxt;
      stun_cnt     <= stun_nxt;
      regen_cnt    <= regen_nxt;
      evt_prev     <= evt_lvl;
      in_hitstun   <= (state_nxt == HITSTUN);
      in_blockstun <= (state_nxt == BLOCKSTUN);
      hurtbox_en   <= (state_nxt != HITSTUN) && (state_nxt != KO);
      ko           <= (state_nxt == KO);
      hit_pulse    <= hit_p_nxt;
      block_pulse  <= block_p_nxt;
      gbreak_pulse <= gbreak_p_nxt;
    end
  end

  assign bus.in_hitstun   = in_hitstun;
  assign bus.in_blockstun = in_blockstun;
  assign bus.hurtbox_en   = hurtbox_en;
  assign bus.ko           = ko;
  assign bus.health       = health;
  assign bus.guard        = guard;
  assign bus.hit_pulse    = hit_pulse;
  assign bus.block_pulse  = block_pulse;
  assign bus.gbreak_pulse = gbreak_pulse;

endmodule

// File: tb/tb_hit_reaction_ctrl.sv
// Scoreboard bench for hit_reaction_ctrl: the driver feeds directed and random
// stimulus into a behavioural model that queues expected outputs; a monitor
// pops and compares one snapshot per clock.
module tb_hit_reaction_ctrl;

  localparam int HM = 100, DMG = 10, GM = 4, HS = 20, BS = 12, GB = 30, GR = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hit_reaction_ctrl_if bus ();

  hit_reaction_ctrl #(
    .HEALTH_MAX(HM), .DAMAGE(DMG), .GUARD_MAX(GM), .HITSTUN_FRAMES(HS),
    .BLOCKSTUN_FRAMES(BS), .GBREAK_FRAMES(GB), .GUARD_REGEN(GR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hs, bst, hb, ko, hp, bp, gp;
    int health, guard;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: stun_left>0 means stunned, stun_hit selects hit- vs block-stun
  int m_health = HM, m_guard = GM, m_stun = 0, m_regen = 0;
  bit m_stun_hit = 0, m_ko = 0, m_prev = 0;

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit rr, input bit t, input bit h, input bit b);
    exp_t e;
    bit lvl, edge_, accept;
    e.hp = 0; e.bp = 0; e.gp = 0;
    if (r || rr) begin
      m_health = HM; m_guard = GM; m_stun = 0; m_regen = 0;
      m_stun_hit = 0; m_ko = 0; m_prev = 0;
    end else begin
      lvl    = h | b;
      edge_  = lvl && !m_prev;
      m_prev = lvl;
      accept = edge_ && !m_ko && (m_stun == 0 || !m_stun_hit);
      if (accept) begin
        m_regen = 0;
        if (h) begin
          e.hp = 1;
          m_health = (m_health > DMG) ? m_health - DMG : 0;
          if (m_health == 0) begin m_ko = 1; m_stun = 0; end
          else begin m_stun = HS; m_stun_hit = 1; end
        end else if (m_guard >= 2) begin
          e.bp = 1; m_guard--; m_stun = BS; m_stun_hit = 0;
        end else begin
          e.hp = 1; e.gp = 1; m_guard = 0; m_stun = GB; m_stun_hit = 1;
        end
      end else if (t && !m_ko) begin
        if (m_stun > 0) m_stun--;
        else begin
          m_regen++;
          if (m_regen == GR) begin
            m_regen = 0;
            if (m_guard < GM) m_guard++;
          end
        end
      end
    end
    e.hs     = !m_ko && m_stun > 0 && m_stun_hit;
    e.bst    = !m_ko && m_stun > 0 && !m_stun_hit;
    e.ko     = m_ko;
    e.hb     = !(m_ko || e.hs);
    e.health = m_health;
    e.guard  = m_guard;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit rr, input bit t, input bit h, input bit b);
    @(negedge clk);
    rst             = r;
    bus.round_reset = rr;
    bus.frame_tick  = t;
    bus.got_hit     = h;
    bus.got_blocked = b;
    model_step(r, rr, t, h, b);
  endtask

  task automatic ticks(input int n, input bit h, input bit b);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, h, b);
      cyc(0, 0, 1, h, b);
    end
  endtask

  // Monitor: one expected snapshot per clock, compared just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("in_hitstun",   int'(bus.in_hitstun),   int'(e.hs));
        check_val("in_blockstun", int'(bus.in_blockstun), int'(e.bst));
        check_val("hurtbox_en",   int'(bus.hurtbox_en),   int'(e.hb));
        check_val("ko",           int'(bus.ko),           int'(e.ko));
        check_val("health",       int'(bus.health),       e.health);
        check_val("guard",        int'(bus.guard),        e.guard);
        check_val("hit_pulse",    int'(bus.hit_pulse),    int'(e.hp));
        check_val("block_pulse",  int'(bus.block_pulse),  int'(e.bp));
        check_val("gbreak_pulse", int'(bus.gbreak_pulse), int'(e.gp));
      end
    end
  end

  initial begin
    bit h, b;
    int n;
    bus.round_reset = 0; bus.frame_tick = 0; bus.got_hit = 0; bus.got_blocked = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Held hit level: one hit, exactly HS ticks of stun, no re-accept
    ticks(40, 1, 0);
    ticks(2, 0, 0);

    // Repeated blocks draining guard down to a guard break
    repeat (5) begin
      cyc(0, 0, 0, 0, 1);
      ticks(32, 0, 0);
    end

    // Hit during blockstun, then block edge ignored during hitstun
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    ticks(7, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    ticks(25, 0, 0);

    // Simultaneous rise is a hit; rst mid-hitstun
    cyc(0, 0, 0, 1, 1);
    ticks(5, 0, 0);
    cyc(1, 0, 0, 0, 0);
    ticks(3, 0, 0);

    // Guard regen and saturation, block near regen rollover
    cyc(0, 0, 0, 0, 1); ticks(13, 0, 0);
    cyc(0, 0, 0, 0, 1); ticks(13, 0, 0);
    ticks(120, 0, 0);
    ticks(59, 0, 0);
    cyc(0, 0, 0, 0, 1);
    ticks(70, 0, 0);

    // Hits to KO, edges ignored while KO, round_reset recovers
    cyc(0, 1, 0, 0, 0);
    repeat (12) begin
      cyc(0, 0, 0, 1, 0);
      ticks(22, 0, 0);
    end
    cyc(0, 0, 0, 0, 1);
    ticks(3, 0, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(3, 0, 0);

    // Random levels, ticks and occasional resets
    h = 0; b = 0;
    repeat (5000) begin
      if ($urandom_range(0, 15) == 0) h = ~h;
      if ($urandom_range(0, 15) == 0) b = ~b;
      cyc(($urandom_range(0, 1999) == 0), ($urandom_range(0, 999) == 0),
          ($urandom_range(0, 2) == 0), h, b);
    end
    cyc(0, 0, 0, 0, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    check_val("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
